input_fetch: RTL and testbench
==============================

INPUT_FETCH -- requirements
Module: input_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width of memory read data.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning memory address width (depth 2**ADDR_W = 64).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled in IDLE only.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, sampled with start.
REQ-007 SHALL have port length  input  ADDR_W+1  word count 0..64, sampled with start.
REQ-008 SHALL have port mem_en  output  1  read enable to the input memory.
REQ-009 SHALL have port mem_addr  output  ADDR_W  read address to the input memory.
REQ-010 SHALL have port mem_data  input  DATA_W  memory read data, valid exactly one cycle after mem_en=1; don't-care (may be Z) otherwise.
REQ-011 SHALL have port out_data  output  DATA_W  streamed word.
REQ-012 SHALL have port out_valid  output  1  out_data holds a word.
REQ-013 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-014 SHALL have port out_last  output  1  marks final word of burst, qualified by out_valid.
REQ-015 SHALL have port sum  output  DATA_W+ADDR_W  running unsigned sum of transferred words.
REQ-016 SHALL have port busy  output  1  high from accepted start until done.
REQ-017 SHALL have port done  output  1  one-cycle pulse after final transfer.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE: on start=1, latch base_addr/length, clear sum, go FETCH (length>0) or DONE (length=0).
REQ-020 FETCH: issue reads mem_en=1, mem_addr=current address, incrementing by 1 per issued read, modulo 64 (63 wraps to 0).
REQ-021 A read SHALL be issued only if (buffered words + reads in flight) < 2, so no data is ever lost under backpressure.
REQ-022 mem_data SHALL be captured only in the cycle following mem_en=1; never sampled otherwise.
REQ-023 Captured words SHALL enter a 2-entry FIFO feeding out_data/out_valid in issue order.
REQ-024 When the last of length reads is issued, FSM SHALL go DRAIN; mem_en=0 from then on.
REQ-025 DRAIN: remain until FIFO empty and nothing in flight, then go DONE.
REQ-026 DONE: done=1 for exactly one cycle, busy=0 that cycle, next state IDLE.
REQ-027 out_last SHALL be 1 while out_valid=1 and the head word is the length-th word of the burst.
REQ-028 sum SHALL add out_data on each transfer, width DATA_W+ADDR_W, no overflow possible for 64 words; holds value after burst until next accepted start.
REQ-029 Minimum latency start -> first out_valid SHALL be 2 cycles (issue next cycle, data captured the cycle after).
REQ-030 With out_ready held 1, throughput SHALL be one word per cycle.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 out_valid SHALL not drop and out_data SHALL not change while out_valid=1 && out_ready=0.
REQ-033 When FSM is not FETCH, mem_en=0 and mem_addr=0.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, mem_en=0, mem_addr=0, out_valid=0, out_data=0, out_last=0, sum=0, busy=0, done=0, FIFO empty, in-flight cleared.
REQ-035 Reset asserted mid-burst SHALL abandon the burst; a read returning after reset release SHALL be discarded.
REQ-036 After rst returns to 1, first accepted start SHALL be the next cycle with start=1.

Verification
REQ-037 Mem[i]=i+1, start base=0 length=4, out_ready=1 -> words 1,2,3,4 on consecutive cycles, out_last with 4, sum=10, one done pulse.
REQ-038 base=62 length=4 -> mem_addr 62,63,0,1; out_data mem[62],mem[63],mem[0],mem[1].
REQ-039 length=8, out_ready toggled 1/0 each cycle -> all 8 words in order, none duplicated/dropped, out_data stable while stalled, mem_en never issues with 2 outstanding.
REQ-040 length=0 -> no mem_en, no out_valid, done pulse one cycle after start, sum=0.
REQ-041 start pulsed mid-burst with different base -> ignored, original burst completes unchanged.
REQ-042 rst=0 after 3 of 8 words -> all outputs zero same cycle; after release, new burst base=10 length=2 returns mem[10],mem[11] only.

Source files
------------

// File: rtl/input_fetch.sv
// Burst reader: fetches `length` words from a 1-cycle-latency memory, streams them through a
// 2-entry FIFO with valid/ready handshake, and accumulates an unsigned sum of transferred words.
module input_fetch #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          length,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [DATA_W+ADDR_W-1:0] sum,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e                     state_q;
    logic [ADDR_W-1:0]          addr_q;
    logic [ADDR_W:0]            len_q;
    logic [ADDR_W:0]            issued_q;
    logic                       infl_q;
    logic                       infl_last_q;
    logic [1:0]                 cnt_q;
    logic [DATA_W-1:0]          head_q;
    logic [DATA_W-1:0]          tail_q;
    logic                       head_last_q;
    logic                       tail_last_q;
    logic [DATA_W+ADDR_W-1:0]   sum_q;
    logic                       busy_q;
    logic                       done_q;

    logic       pop;
    logic       push;
    logic       issue;
    logic       issue_last;
    logic [2:0] occ;

    // The word leaving this cycle frees its slot, so it is credited before deciding to issue;
    // this keeps one word per cycle while never exceeding two buffered-or-pending words.
    always_comb begin
        pop        = (cnt_q != 2'd0) && out_ready;
        push       = infl_q;
        occ        = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
        issue      = (state_q == StFetch) && (occ < 3'd2);
        issue_last = (issued_q + 1'b1) == len_q;
    end

    assign mem_en    = issue;
    assign mem_addr  = (state_q == StFetch) ? addr_q : '0;
    assign out_data  = head_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_last  = out_valid && head_last_q;
    assign sum       = sum_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        addr_q   <= base_addr;
                        len_q    <= length;
                        issued_q <= '0;
                        if (length == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StFetch;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (issue) begin
                        addr_q   <= addr_q + 1'b1;
                        issued_q <= issued_q + 1'b1;
                        if (issue_last) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (!infl_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return tracking, 2-entry FIFO and running sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            cnt_q       <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            head_last_q <= 1'b0;
            tail_last_q <= 1'b0;
            sum_q       <= '0;
        end else begin
            infl_q      <= issue;
            infl_last_q <= issue && issue_last;
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        head_q      <= mem_data;
                        head_last_q <= infl_last_q;
                        cnt_q       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q      <= mem_data;
                        head_last_q <= infl_last_q;
                    end else if (push) begin
                        tail_q      <= mem_data;
                        tail_last_q <= infl_last_q;
                        cnt_q       <= 2'd2;
                    end else if (pop) begin
                        cnt_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q      <= tail_q;
                        head_last_q <= tail_last_q;
                        if (push) begin
                            tail_q      <= mem_data;
                            tail_last_q <= infl_last_q;
                        end else begin
                            cnt_q <= 2'd1;
                        end
                    end
                end
                default: cnt_q <= 2'd0;
            endcase
            if ((state_q == StIdle) && start) begin
                sum_q <= '0;
            end else if (pop) begin
                sum_q <= sum_q + {{ADDR_W{1'b0}}, head_q};
            end
        end
    end

endmodule

// File: tb/tb_input_fetch.sv
// Self-checking bench for input_fetch: memory model, address/data scoreboard, table of bursts
// and hand-written sequences for latency, ignored start and mid-burst reset.
module tb_input_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  base_addr = '0;
    logic [6:0]  length = '0;
    logic        mem_en;
    logic [5:0]  mem_addr;
    logic [31:0] mem_data = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [37:0] sum;
    logic        busy;
    logic        done;

    input_fetch #(.DATA_W(32), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .sum       (sum),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    typedef struct {
        int base;
        int len;
        int mode;     // 0: ready held 1, 1: ready toggles, 2: ready random
        int exp_sum;
    } vec_t;

    logic [31:0] mem [64];
    exp_t        exp_q [$];
    logic [5:0]  exp_addr [$];
    int          xfer_cyc [$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          issued = 0;
    int          xfers = 0;
    int          done_total = 0;
    int          done_base = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;
    vec_t        vecs [6];

    initial for (int i = 0; i < 64; i++) mem[i] = i + 1;

    // Data is only meaningful the cycle after mem_en; otherwise drive garbage.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_data <= mem[mem_addr];
        else        mem_data <= $urandom();
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_total++;
        $display("FAIL %s: event seen but none expected", name);
    endtask

    always @(negedge clk) begin
        logic xfer;
        logic [5:0] a;
        exp_t e;
        if (!rst) begin
            exp_q.delete();
            exp_addr.delete();
            issued = 0;
            xfers = 0;
            stall_prev = 1'b0;
        end else begin
            xfer = out_valid && out_ready;
            if (mem_en) begin
                if (exp_addr.size() == 0) note_fail("unexpected mem_en");
                else begin
                    a = exp_addr.pop_front();
                    check("mem_addr", mem_addr, a);
                end
                check("outstanding<2", (issued - xfers - int'(xfer)) < 2, 1);
                issued++;
            end else if (!busy) begin
                check("idle mem_addr", mem_addr, 0);
            end
            if (stall_prev) begin
                check("stall out_valid", out_valid, 1);
                check("stall out_data", out_data, prev_data);
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            if (!out_valid) check("out_last w/o valid", out_last, 0);
            if (xfer) begin
                if (exp_q.size() == 0) note_fail("extra word");
                else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", out_last, e.l);
                end
                xfer_cyc.push_back(cyc);
                xfers++;
            end
            if (done) begin
                done_total++;
                done_cyc = cyc;
                check("busy low in done", busy, 0);
            end
        end
    end

    task automatic launch(input int base, input int len);
        int a;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 6'(base);
        length = 7'(len);
        for (int i = 0; i < len; i++) begin
            a = (base + i) % 64;
            exp_q.push_back({mem[a], i == len - 1});
            exp_addr.push_back(6'(a));
        end
        start_cyc = cyc;
        done_base = done_total;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_burst(input int mode);
        int k = 0;
        while (done_total == done_base && k < 400) begin
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = ~out_ready;
            else                out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
        end
        if (done_total == done_base) note_fail("done timeout");
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("done pulse count", done_total - done_base, 1);
        check("words left", exp_q.size(), 0);
        check("addrs left", exp_addr.size(), 0);
    endtask

    initial begin
        vecs[0] = '{base: 0,  len: 4,  mode: 0, exp_sum: 10};
        vecs[1] = '{base: 62, len: 4,  mode: 0, exp_sum: 130};
        vecs[2] = '{base: 5,  len: 8,  mode: 1, exp_sum: 76};
        vecs[3] = '{base: 20, len: 0,  mode: 0, exp_sum: 0};
        vecs[4] = '{base: 0,  len: 64, mode: 2, exp_sum: 2080};
        vecs[5] = '{base: 63, len: 3,  mode: 1, exp_sum: 67};

        #12;
        check("reset outputs", {mem_en, mem_addr, out_valid, out_data, out_last, sum, busy, done},
              0);
        @(negedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;

        // Latency and throughput: first word 3 cycles after the start cycle, then one per cycle.
        xfer_cyc.delete();
        launch(0, 4);
        check("busy after start", busy, 1);
        finish_burst(0);
        check("burst of 4 count", xfer_cyc.size(), 4);
        if (xfer_cyc.size() == 4) begin
            check("first word cycle", xfer_cyc[0] - start_cyc, 3);
            check("last word cycle", xfer_cyc[3] - start_cyc, 6);
        end
        check("done cycle", done_cyc - start_cyc, 7);
        check("sum 1..4", sum, 10);

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].base, vecs[i].len);
            finish_burst(vecs[i].mode);
            check("vector sum", sum, vecs[i].exp_sum);
            if (vecs[i].len == 0) check("len0 done timing", done_cyc - start_cyc, 1);
        end

        // Start while busy must be ignored.
        launch(30, 6);
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 6'd0;
        length = 7'd2;
        @(posedge clk); #1;
        start = 1'b0;
        finish_burst(0);
        check("ignored start sum", sum, 201);

        // Reset mid-burst abandons everything, then a fresh burst runs cleanly.
        launch(0, 8);
        begin
            int k = 0;
            out_ready = 1'b1;
            while (xfers < 3 && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            if (xfers < 3) note_fail("reset test timeout");
        end
        rst = 1'b0;
        #1;
        check("mid-burst reset outputs",
              {mem_en, mem_addr, out_valid, out_data, out_last, sum, busy, done}, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        launch(10, 2);
        finish_burst(0);
        check("post-reset sum", sum, 23);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
